// File: rtl/adder4_rc.sv
// rtl/adder4_rc.sv - 4-bit ripple-carry adder with a registered result stage
// A chain of four full adders, plus a registered copy of the result and its signed-overflow flag.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module adder4_rc (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  input  logic       en,
  output logic [3:0] s,
  output logic       co,
  output logic [3:0] s_q,
  output logic       co_q,
  output logic       ovf_q,
  output logic       vld_q
);

  logic [4:0] c;
  logic       ovf;

  assign c[0] = ci;

  full_adder u_fa0 (.a(a[0]), .b(b[0]), .ci(c[0]), .s(s[0]), .co(c[1]));
  full_adder u_fa1 (.a(a[1]), .b(b[1]), .ci(c[1]), .s(s[1]), .co(c[2]));
  full_adder u_fa2 (.a(a[2]), .b(b[2]), .ci(c[2]), .s(s[2]), .co(c[3]));
  full_adder u_fa3 (.a(a[3]), .b(b[3]), .ci(c[3]), .s(s[3]), .co(c[4]));

  assign co = c[4];

  // Signed overflow: the carry into the sign bit disagrees with the carry out of it.
  assign ovf = c[3] ^ c[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= 4'b0000;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (en) begin
      s_q   <= s;
      co_q  <= co;
      ovf_q <= ovf;
      vld_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder4_rc.sv
// tb/tb_adder4_rc.sv - self-checking bench for adder4_rc
// Directed, exhaustive and random vectors against an arithmetic reference model.

module tb_adder4_rc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       ci;
  logic       en;
  logic [3:0] s;
  logic       co;
  logic [3:0] s_q;
  logic       co_q;
  logic       ovf_q;
  logic       vld_q;

  int n_vec  = 0;
  int n_fail = 0;

  logic [3:0] m_s;
  logic       m_co;
  logic       m_ovf;
  logic       m_vld;

  adder4_rc dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .en(en),
    .s(s), .co(co), .s_q(s_q), .co_q(co_q), .ovf_q(ovf_q), .vld_q(vld_q)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_sum(input logic [3:0] x, input logic [3:0] y, input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return t[4:0];
  endfunction

  function automatic logic ref_ovf(input logic [3:0] x, input logic [3:0] y, input logic c);
    int sx;
    int sy;
    int t;
    sx = x[3] ? int'(x) - 16 : int'(x);
    sy = y[3] ? int'(y) - 16 : int'(y);
    t  = sx + sy + int'(c);
    return (t > 7) || (t < -8);
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b (a=%b b=%b ci=%b)", tag, obs, exp, a, b, ci);
    end
  endtask

  task automatic check_comb(input string tag);
    check(tag, {2'b00, co, s}, {2'b00, ref_sum(a, b, ci)});
  endtask

  task automatic check_regs(input string tag);
    check(tag, {vld_q, ovf_q, co_q, s_q}, {m_vld, m_ovf, m_co, m_s});
  endtask

  task automatic apply(input logic [3:0] x, input logic [3:0] y, input logic c);
    a  = x;
    b  = y;
    ci = c;
    #10;
  endtask

  // Inputs are stable at this point; predict the edge, take it, then compare.
  task automatic clock_step(input string tag);
    logic [4:0] sum;
    if (en && !rst) begin
      sum   = ref_sum(a, b, ci);
      m_s   = sum[3:0];
      m_co  = sum[4];
      m_ovf = ref_ovf(a, b, ci);
      m_vld = 1'b1;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; a = 4'd0; b = 4'd0; ci = 1'b0;
    m_s = 4'd0; m_co = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
    #1;
    check("reset_regs", {vld_q, ovf_q, co_q, s_q}, 7'b0000000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    apply(4'b0000, 4'b0000, 1'b0); check("zeros",       {2'b00, co, s}, 7'b0000000);
    apply(4'b0000, 4'b0000, 1'b1); check("ci_only",     {2'b00, co, s}, 7'b0000001);
    apply(4'b1111, 4'b0000, 1'b1); check("full_ripple", {2'b00, co, s}, 7'b0010000);
    apply(4'b1111, 4'b1111, 1'b1); check("max",         {2'b00, co, s}, 7'b0011111);
    apply(4'b0011, 4'b0101, 1'b0); check("3_plus_5",    {2'b00, co, s}, 7'b0001000);

    for (int i = 0; i < 512; i++) begin
      apply(4'(i >> 5), 4'(i >> 1), i[0]);
      check_comb("exhaustive");
    end
    check_regs("hold_after_exhaustive");

    @(negedge clk);
    a = 4'b0111; b = 4'b0001; ci = 1'b0; en = 1'b1;
    clock_step("ovf_7p1_model");
    check("ovf_7p1", {vld_q, ovf_q, co_q, s_q}, 7'b1101000);
    @(negedge clk);
    a = 4'b1000; b = 4'b1000; ci = 1'b0;
    clock_step("ovf_8p8_model");
    check("ovf_8p8", {vld_q, ovf_q, co_q, s_q}, 7'b1110000);

    @(negedge clk);
    en = 1'b0; a = 4'b0101; b = 4'b0110; ci = 1'b1;
    clock_step("hold_en0_a");
    @(negedge clk);
    a = 4'b1111; b = 4'b1111;
    clock_step("hold_en0_b");

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a  = 4'($urandom_range(15));
      b  = 4'($urandom_range(15));
      ci = 1'($urandom_range(1));
      en = 1'($urandom_range(1));
      #1;
      check_comb("rand_comb");
      clock_step("rand_regs");
    end

    @(negedge clk);
    a = 4'b0110; b = 4'b0011; ci = 1'b0; en = 1'b1;
    clock_step("pre_reset");
    @(negedge clk);
    rst = 1'b1; a = 4'b1001; b = 4'b1000; ci = 1'b1;
    m_s = 4'd0; m_co = 1'b0; m_ovf = 1'b0; m_vld = 1'b0;
    #1;
    check("async_reset", {vld_q, ovf_q, co_q, s_q}, 7'b0000000);
    check_comb("comb_during_reset");
    clock_step("reset_beats_en");
    @(negedge clk);
    rst = 1'b0; a = 4'b0100; b = 4'b0100; ci = 1'b0;
    clock_step("first_en_after_reset");
    check("vld_after_reset", {6'd0, vld_q}, 7'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
